cfg_loader: RTL and testbench

// - Bitstream loader directly upstream of the fabric cells: takes a byte-wide

---
 rtl/cfg_loader_pkg.sv | 26 ++
 rtl/cfg_loader_byte_acc.sv | 42 ++++
 rtl/cfg_loader.sv | 114 +++++++++++
 tb/tb_cfg_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration loader: frame layout, FSM states,
// and the stream byte-count helper.
package cfg_loader_pkg;

  // Config bits per fabric cell and the field layout inside one frame.
  localparam int CFG_FRAME_W = 31;
  localparam int CFG_CB_LSB  = 0;
  localparam int CFG_CB_W    = 10;
  localparam int CFG_CLB_LSB = 10;
  localparam int CFG_CLB_W   = 5;
  localparam int CFG_SB_LSB  = 15;
  localparam int CFG_SB_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3
  } cfg_state_t;

  // Number of stream bytes needed to carry nbits config bits (last byte padded).
  function automatic int cfg_nbytes(input int nbits);
    return (nbits + 7) / 8;
  endfunction

endpackage

// File: rtl/cfg_loader_byte_acc.sv
// Byte accumulator: shadow register filled LSB-first, byte index and
// running XOR checksum. Clear resets index and checksum only; the shadow is
// completely overwritten by every full load so it needs no clearing.
module cfg_byte_acc
  import cfg_loader_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int IDX_W  = $clog2(NBYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   wr,
  input  logic [7:0]             data,
  output logic [NBYTES-1:0][7:0] shadow,
  output logic [IDX_W-1:0]       idx,
  output logic [7:0]             chk
);

  // Index and checksum advance once per accepted byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      chk <= '0;
    end else if (clr) begin
      idx <= '0;
      chk <= '0;
    end else if (wr) begin
      idx <= idx + 1'b1;
      chk <= chk ^ data;
    end
  end

  // One write-enabled byte lane per shadow byte, selected by the index.
  for (genvar b = 0; b < NBYTES; b++) begin : g_byte
    always_ff @(posedge clk or posedge reset) begin
      if (reset) shadow[b] <= '0;
      else if (wr && idx == IDX_W'(b)) shadow[b] <= data;
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Bitstream loader: collects a byte stream into a shadow register, verifies
// the trailing XOR checksum, then commits the shadow to the live config bus
// in a single cycle. fabric_rst holds the cells in reset while no checked
// configuration is live.
module cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int NUM_CELLS = 4,
  parameter int FRAME_W   = CFG_FRAME_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [NUM_CELLS*FRAME_W-1:0] cfg_bits,
  output logic                         cfg_valid,
  output logic                         fabric_rst,
  output logic                         done,
  output logic                         cfg_err,
  output logic                         busy
);

  localparam int CFG_W  = NUM_CELLS * FRAME_W;
  localparam int NBYTES = cfg_nbytes(CFG_W);
  localparam int IDX_W  = $clog2(NBYTES + 1);

  cfg_state_t              state;
  logic [NBYTES-1:0][7:0]  shadow;
  logic [8*NBYTES-1:0]     shadow_flat;
  logic [IDX_W-1:0]        idx;
  logic [7:0]              chk;
  logic                    xfer;
  logic                    acc_clr;
  logic                    acc_wr;

  // Abort blocks acceptance so a byte offered alongside it is never consumed.
  assign in_ready   = (state == ST_LOAD || state == ST_CHECK) && !abort;
  assign xfer       = in_valid && in_ready;
  assign acc_clr    = (state == ST_IDLE) && start && !abort;
  assign acc_wr     = (state == ST_LOAD) && xfer;
  assign busy       = (state != ST_IDLE);
  assign fabric_rst = ~cfg_valid;
  assign shadow_flat = shadow;

  // Padding bits in the last stream byte never reach the cells.
  if (8 * NBYTES > CFG_W) begin : g_pad
    logic pad_unused;
    assign pad_unused = ^shadow_flat[8*NBYTES-1:CFG_W];
  end

  cfg_byte_acc #(
    .NBYTES (NBYTES),
    .IDX_W  (IDX_W)
  ) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clr    (acc_clr),
    .wr     (acc_wr),
    .data   (in_data),
    .shadow (shadow),
    .idx    (idx),
    .chk    (chk)
  );

  // Load sequencing, checksum verdict and the one-cycle commit to the live bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cfg_bits  <= '0;
      cfg_valid <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cfg_err   <= 1'b0;
              cfg_valid <= 1'b0;
              state     <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (xfer && idx == IDX_W'(NBYTES - 1)) state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (xfer) begin
              if (in_data == chk) begin
                state <= ST_COMMIT;
              end else begin
                cfg_err <= 1'b1;
                state   <= ST_IDLE;
              end
            end
          end
          ST_COMMIT: begin
            cfg_bits  <= shadow_flat[CFG_W-1:0];
            cfg_valid <= 1'b1;
            done      <= 1'b1;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader (4 cells, 16 stream bytes). Expected
// configuration is built from the LSB-first bit mapping over the byte array.
module tb_cfg_loader;

  localparam int NC  = 4;
  localparam int CW  = NC * 31;
  localparam int NB  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] cfg_bits;
  logic          cfg_valid;
  logic          fabric_rst;
  logic          done;
  logic          cfg_err;
  logic          busy;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;

  logic [7:0]    stim [NB];
  logic [CW-1:0] exp_cfg = '0;
  logic          exp_valid = 1'b0;
  logic          exp_err = 1'b0;

  cfg_loader #(.NUM_CELLS(NC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_bits(cfg_bits), .cfg_valid(cfg_valid), .fabric_rst(fabric_rst),
    .done(done), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference: stream bit n = byte n/8, bit n%8 -> cfg bit n.
  function automatic logic [CW-1:0] model_cfg();
    logic [CW-1:0] e;
    for (int n = 0; n < CW; n++) e[n] = stim[n / 8][n % 8];
    return e;
  endfunction

  function automatic logic [7:0] model_chk();
    logic [7:0] c = '0;
    for (int i = 0; i < NB; i++) c = c ^ stim[i];
    return c;
  endfunction

  // Outputs against the bench's own view of the live state.
  task automatic check_state(input string tag);
    checks++;
    if (cfg_bits !== exp_cfg) $display("FAIL %s cfg_bits got %h want %h", tag, cfg_bits, exp_cfg);
    else passed++;
    checks++;
    if ({cfg_valid, fabric_rst, cfg_err, busy} !== {exp_valid, ~exp_valid, exp_err, 1'b0})
      $display("FAIL %s valid/rst/err/busy got %b%b%b%b want %b%b%b0", tag,
               cfg_valid, fabric_rst, cfg_err, busy, exp_valid, ~exp_valid, exp_err);
    else passed++;
  endtask

  // Present one byte (after a random gap) and hold it until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g, tries;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    in_valid = 1'b0;
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    tries = 0;
    #1;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_byte timeout in_ready got 0 want 1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_err   = 1'b0;
    exp_valid = 1'b0;
  endtask

  // Full load of stim[] plus checksum ck; checks done timing and final state.
  task automatic do_load(input logic [7:0] ck, input int max_gap, input string tag);
    logic good;
    good = (ck == model_chk());
    pulse_start();
    done_cnt = 0;
    for (int i = 0; i < NB; i++) send_byte(stim[i], max_gap);
    send_byte(ck, max_gap);
    // Now one negedge past the checksum transfer: done not yet.
    checks++;
    if (done !== 1'b0) $display("FAIL %s done_early got %b want 0", tag, done);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== good) $display("FAIL %s done_pulse got %b want %b", tag, done, good);
    else passed++;
    @(negedge clk);
    if (good) begin
      exp_cfg   = model_cfg();
      exp_valid = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
    checks++;
    if (done_cnt !== (good ? 1 : 0)) $display("FAIL %s done_count got %0d want %0d", tag, done_cnt, good ? 1 : 0);
    else passed++;
    check_state(tag);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cfg_bits, cfg_valid, fabric_rst, in_ready, done, cfg_err, busy} !== {{CW{1'b0}}, 6'b010000})
      $display("FAIL reset_hold outputs got %h/%b%b%b%b%b%b want 0/010000", cfg_bits,
               cfg_valid, fabric_rst, in_ready, done, cfg_err, busy);
    else passed++;
    reset = 1'b0;
    pulse_start();
    send_byte(8'h3C, 0);
    send_byte(8'hC3, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({cfg_valid, fabric_rst, in_ready, done, cfg_err, busy} !== 6'b010000 || cfg_bits !== '0)
      $display("FAIL reset_async outputs got %b%b%b%b%b%b want 010000", cfg_valid, fabric_rst,
               in_ready, done, cfg_err, busy);
    else passed++;
    exp_cfg = '0; exp_valid = 1'b0; exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_good_load();
    for (int i = 0; i < NB; i++) stim[i] = 8'(i);
    do_load(8'h00, 0, "good");
    checks++;
    if ({cfg_bits[123:120], cfg_bits[15:8], cfg_bits[7:0]} !== {4'hF, 8'h01, 8'h00})
      $display("FAIL good_fields got %h %h %h want f 01 00", cfg_bits[123:120], cfg_bits[15:8], cfg_bits[7:0]);
    else passed++;
  endtask

  task automatic test_bad_checksum();
    logic [CW-1:0] prev;
    prev = cfg_bits;
    for (int i = 0; i < NB; i++) stim[i] = 8'hA5;
    do_load(8'h01, 0, "badchk");
    checks++;
    if (cfg_bits !== prev) $display("FAIL badchk_keep cfg_bits got %h want %h", cfg_bits, prev);
    else passed++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < NB; i++) stim[i] = 8'(i);
    do_load(8'h00, 5, "bp");
  endtask

  task automatic test_abort();
    for (int i = 0; i < NB; i++) stim[i] = 8'($urandom);
    pulse_start();
    done_cnt = 0;
    for (int i = 0; i < 7; i++) send_byte(stim[i], 0);
    in_valid = 1'b1;
    in_data  = stim[7];
    abort    = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL abort_ready got %b want 0", in_ready);
    else passed++;
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    check_state("abort");
    checks++;
    if (done_cnt !== 0) $display("FAIL abort_done got %0d want 0", done_cnt);
    else passed++;
    // start+abort together in IDLE: stays IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_state("abort_start");
    do_load(model_chk(), 0, "post_abort");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NB; i++) stim[i] = 8'($urandom);
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(stim[i], 0);
    #2 reset = 1'b1;
    exp_cfg = '0; exp_valid = 1'b0; exp_err = 1'b0;
    #1;
    check_state("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NB; i++) stim[i] = 8'hFF;
    do_load(8'h00, 0, "ones");
    checks++;
    if (cfg_bits !== {CW{1'b1}}) $display("FAIL ones_all got %h want all ones", cfg_bits);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] ck;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NB; i++) stim[i] = 8'($urandom);
      ck = model_chk();
      if ($urandom_range(0, 2) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      do_load(ck, 3, "random");
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
